// File: rtl/udp_stack_pkg.sv
// Shared definitions for the UDP receive reassembly block.
//   state_e      : reassembly FSM state encoding
//   CMD_TAG      : tdata[63:62] value that marks a command datagram
//   ERR_*        : bit positions inside err_status
package udp_stack_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_CMD = 3'd0,
    ST_RECV     = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_ABORT    = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam logic [1:0] CMD_TAG = 2'b11;

  localparam int unsigned ERR_WIDTH    = 4;
  localparam int unsigned ERR_TUSER    = 0;
  localparam int unsigned ERR_FRAG_LEN = 1;
  localparam int unsigned ERR_OVERRUN  = 2;
  localparam int unsigned ERR_TIMEOUT  = 3;

endpackage

// File: rtl/udp_reassembly_if.sv
// AXI-Stream bundle used for both the UDP payload input and the DMA output.
//   master : drives tdata/tkeep/tvalid/tlast/tuser, samples tready
//   slave  : samples tdata/tkeep/tvalid/tlast/tuser, drives tready
interface udp_reassembly_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/udp_reassembly.sv
// Receive-side reassembly: waits for a command datagram announcing a transfer
// size, then concatenates mss-beat fragments into one stream of exactly size
// beats with a single tlast, flagging length/overrun/tuser errors and closing
// a stalled transfer by timeout.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   s_udp_payload_axis  : UDP RX payload stream (slave)
//   m_axis              : stream to DMA S2MM (master), combinational in RECV
//   mss, timeout        : beats per fragment, idle cycle limit (0 = off)
//   control_dma         : latched command {1'b1, cmd[62:0]}
//   busy, done          : transfer in progress, normal completion pulse
//   err_status          : sticky {timeout, overrun, frag_len, tuser}
//   frag_count          : fragments received in current/last transfer
module udp_reassembly
  import udp_stack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  udp_reassembly_if.slave       s_udp_payload_axis,
  udp_reassembly_if.master      m_axis,
  input  logic [31:0]           mss,
  input  logic [31:0]           timeout,
  output logic [63:0]           control_dma,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_WIDTH-1:0]  err_status,
  output logic [CNT_WIDTH-1:0]  frag_count
);

  state_e                 r_state;
  logic [CNT_WIDTH-1:0]   r_size;
  logic [CNT_WIDTH-1:0]   r_beat_cnt;
  logic [CNT_WIDTH-1:0]   r_frag_beat;
  logic [CNT_WIDTH-1:0]   r_idle_cnt;
  logic [CNT_WIDTH-1:0]   r_frag_count;
  logic [ERR_WIDTH-1:0]   r_err;
  logic [63:0]            r_control_dma;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_hs;
  logic                   w_final;
  logic                   w_is_cmd;
  logic                   w_frag_short;
  logic                   w_tmo_hit;
  logic [CNT_WIDTH-1:0]   w_cmd_size;
  logic [CNT_WIDTH-1:0]   w_size_m1;
  logic [CNT_WIDTH-1:0]   w_mss_m1;
  logic [CNT_WIDTH-1:0]   w_tmo_m1;

  // Decode of the current beat against the transfer counters
  assign w_cmd_size   = CNT_WIDTH'(s_udp_payload_axis.tdata[31:0]);
  assign w_size_m1    = r_size - CNT_WIDTH'(1);
  assign w_mss_m1     = CNT_WIDTH'(mss) - CNT_WIDTH'(1);
  assign w_tmo_m1     = CNT_WIDTH'(timeout) - CNT_WIDTH'(1);
  assign w_final      = (r_beat_cnt == w_size_m1);
  // Only meaningful in RECV, where s ready mirrors m ready
  assign w_hs         = s_udp_payload_axis.tvalid & m_axis.tready;
  // Zero-size commands are ignored altogether
  assign w_is_cmd     = s_udp_payload_axis.tvalid & s_udp_payload_axis.tlast &
                        (s_udp_payload_axis.tdata[63:62] == CMD_TAG) &
                        (w_cmd_size != '0);
  // A short final fragment is legal; mss==0 disables the check
  assign w_frag_short = (mss != 32'd0) & (r_frag_beat != w_mss_m1) & ~w_final;
  assign w_tmo_hit    = (timeout != 32'd0) & (r_idle_cnt >= w_tmo_m1);

  // Stream steering: zero-latency pass-through in RECV, forced error beat in ABORT
  always_comb begin
    s_udp_payload_axis.tready = 1'b0;
    m_axis.tvalid             = 1'b0;
    m_axis.tdata              = '0;
    m_axis.tkeep              = '0;
    m_axis.tlast              = 1'b0;
    m_axis.tuser              = 1'b0;
    unique case (r_state)
      ST_WAIT_CMD, ST_DRAIN: s_udp_payload_axis.tready = 1'b1;
      ST_RECV: begin
        s_udp_payload_axis.tready = m_axis.tready;
        m_axis.tvalid             = s_udp_payload_axis.tvalid;
        m_axis.tdata              = s_udp_payload_axis.tdata;
        m_axis.tkeep              = s_udp_payload_axis.tkeep;
        m_axis.tlast              = w_final;
        m_axis.tuser              = s_udp_payload_axis.tuser;
      end
      ST_ABORT: begin
        m_axis.tvalid = 1'b1;
        m_axis.tkeep  = '1;
        m_axis.tlast  = 1'b1;
        m_axis.tuser  = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM, counters and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_WAIT_CMD;
      r_size        <= '0;
      r_beat_cnt    <= '0;
      r_frag_beat   <= '0;
      r_idle_cnt    <= '0;
      r_frag_count  <= '0;
      r_err         <= '0;
      r_control_dma <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_WAIT_CMD: begin
          if (w_is_cmd) begin
            r_size        <= w_cmd_size;
            r_control_dma <= {1'b1, s_udp_payload_axis.tdata[62:0]};
            r_err         <= '0;
            r_frag_count  <= '0;
            r_beat_cnt    <= '0;
            r_frag_beat   <= '0;
            r_idle_cnt    <= '0;
            r_busy        <= 1'b1;
            r_state       <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (w_hs) begin
            r_beat_cnt  <= r_beat_cnt + CNT_WIDTH'(1);
            r_idle_cnt  <= '0;
            r_frag_beat <= s_udp_payload_axis.tlast ? '0 : r_frag_beat + CNT_WIDTH'(1);
            if (s_udp_payload_axis.tlast) begin
              r_frag_count <= r_frag_count + CNT_WIDTH'(1);
              if (w_frag_short) r_err[ERR_FRAG_LEN] <= 1'b1;
            end
            if (s_udp_payload_axis.tuser) r_err[ERR_TUSER] <= 1'b1;
            if (w_final) begin
              if (s_udp_payload_axis.tlast) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                // Sender still has data beyond size: swallow rest of datagram
                r_err[ERR_OVERRUN] <= 1'b1;
                r_state            <= ST_DRAIN;
              end
            end
          end else begin
            r_idle_cnt <= r_idle_cnt + CNT_WIDTH'(1);
            if (w_tmo_hit) begin
              r_err[ERR_TIMEOUT] <= 1'b1;
              r_state            <= ST_ABORT;
            end
          end
        end
        ST_DRAIN: begin
          if (s_udp_payload_axis.tvalid && s_udp_payload_axis.tlast) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_ABORT: begin
          if (m_axis.tready) begin
            r_state <= ST_WAIT_CMD;
            r_busy  <= 1'b0;
          end
        end
        ST_DONE: r_state <= ST_WAIT_CMD;
        default: r_state <= ST_WAIT_CMD;
      endcase
    end
  end

  assign control_dma = r_control_dma;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_status  = r_err;
  assign frag_count  = r_frag_count;

endmodule

// File: tb/tb_udp_reassembly.sv
// Directed bench for udp_reassembly: table of transfer scenarios plus
// hand-written sequences for ignored commands and reset mid-transfer.
module tb_udp_reassembly;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = 8;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   mss;
  logic [31:0]   timeout;
  logic [63:0]   control_dma;
  logic          busy;
  logic          done;
  logic [3:0]    err_status;
  logic [CW-1:0] frag_count;

  udp_reassembly_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_if ();
  udp_reassembly_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m_if ();

  udp_reassembly #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_udp_payload_axis (s_if),
    .m_axis             (m_if),
    .mss                (mss),
    .timeout            (timeout),
    .control_dma        (control_dma),
    .busy               (busy),
    .done               (done),
    .err_status         (err_status),
    .frag_count         (frag_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic        is_cmd;
    int          cyc;
  } beat_t;

  typedef struct {
    int          size, mss, tmo;
    int          f0, f1, f2;
    int          stop_after;
    int          user_beat;
    bit          bp;
    int          exp_beats;
    logic [3:0]  exp_err;
    int          exp_done;
    int          exp_frag;
    bit          exp_abort;
  } vec_t;

  beat_t       src_q[$];
  beat_t       out_q[$];
  vec_t        vecs[8];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cnt;
  int          last_acc_cyc;
  int          pay_acc;
  bit          seen_busy;
  logic [63:0] exp_ctl = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int vi, input int j);
    return 64'h5A00_0000_0000_0000 | (64'(vi) << 32) | 64'(j);
  endfunction

  task automatic drive_head();
    if (src_q.size() != 0) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = src_q[0].data;
      s_if.tkeep  = src_q[0].keep;
      s_if.tlast  = src_q[0].last;
      s_if.tuser  = src_q[0].user;
    end else begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, cross the posedge
  task automatic step(input bit bp);
    beat_t b;
    bit    acc;
    drive_head();
    m_if.tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    acc = s_if.tvalid && s_if.tready;
    if (m_if.tvalid && m_if.tready) begin
      b.data = m_if.tdata; b.keep = m_if.tkeep; b.last = m_if.tlast;
      b.user = m_if.tuser; b.is_cmd = 1'b0; b.cyc = cyc;
      out_q.push_back(b);
    end
    if (done) done_cnt++;
    if (busy) seen_busy = 1'b1;
    if (acc) begin
      if (!src_q[0].is_cmd) begin
        last_acc_cyc = cyc;
        pay_acc++;
      end
      void'(src_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_cmd(input int vi, input int size);
    beat_t       b;
    logic [63:0] cmd;
    cmd = {2'b11, 30'(vi), 32'(size)};
    b.data = cmd; b.keep = 8'hFF; b.last = 1'b1; b.user = 1'b0;
    b.is_cmd = 1'b1; b.cyc = 0;
    src_q.push_back(b);
    exp_ctl = {1'b1, cmd[62:0]};
  endtask

  task automatic push_payload(input int vi, input int n, input int f0, input int f1,
                              input int tot, input int user_beat);
    beat_t b;
    for (int j = 0; j < n; j++) begin
      b.data   = pat(vi, j);
      b.keep   = (j % 2 == 1) ? 8'h0F : 8'hFF;
      b.last   = (j == f0 - 1) || (j == f0 + f1 - 1) || (j == tot - 1);
      b.user   = (j == user_beat - 1);
      b.is_cmd = 1'b0;
      b.cyc    = 0;
      src_q.push_back(b);
    end
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int tot, n_send, nb;
    bit fin;
    logic [63:0] ed;
    logic [7:0]  ek;
    logic        el, eu;
    src_q.delete(); out_q.delete();
    done_cnt = 0; seen_busy = 1'b0; last_acc_cyc = 0; pay_acc = 0;
    mss = 32'(v.mss); timeout = 32'(v.tmo);
    push_cmd(vi, v.size);
    tot    = v.f0 + v.f1 + v.f2;
    n_send = (v.stop_after >= 0) ? v.stop_after : tot;
    push_payload(vi, n_send, v.f0, v.f1, tot, v.user_beat);
    fin = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      step(v.bp);
      if (src_q.size() == 0 && seen_busy && !busy && !done) fin = 1'b1;
    end
    if (!fin) begin
      n_chk++; n_fail++;
      $display("FAIL vec%0d_finish: transfer still open after 600 cycles", vi);
    end
    chk($sformatf("vec%0d_beats", vi), 64'(out_q.size()), 64'(v.exp_beats));
    nb = (out_q.size() < v.exp_beats) ? out_q.size() : v.exp_beats;
    for (int j = 0; j < nb; j++) begin
      if (v.exp_abort && j == v.exp_beats - 1) begin
        ed = '0; ek = 8'hFF; el = 1'b1; eu = 1'b1;
      end else begin
        ed = pat(vi, j);
        ek = (j % 2 == 1) ? 8'h0F : 8'hFF;
        el = (j == v.size - 1);
        eu = (j == v.user_beat - 1);
      end
      chk($sformatf("vec%0d_b%0d_data", vi, j), out_q[j].data, ed);
      chk($sformatf("vec%0d_b%0d_keep", vi, j), 64'(out_q[j].keep), 64'(ek));
      chk($sformatf("vec%0d_b%0d_last", vi, j), 64'(out_q[j].last), 64'(el));
      chk($sformatf("vec%0d_b%0d_user", vi, j), 64'(out_q[j].user), 64'(eu));
    end
    chk($sformatf("vec%0d_done", vi), 64'(done_cnt), 64'(v.exp_done));
    chk($sformatf("vec%0d_err", vi), 64'(err_status), 64'(v.exp_err));
    chk($sformatf("vec%0d_frag_count", vi), 64'(frag_count), 64'(v.exp_frag));
    chk($sformatf("vec%0d_control_dma", vi), control_dma, exp_ctl);
    chk($sformatf("vec%0d_busy_end", vi), 64'(busy), 64'd0);
    if (v.exp_abort && out_q.size() != 0)
      chk($sformatf("vec%0d_tmo_gap", vi),
          64'(out_q[out_q.size() - 1].cyc - last_acc_cyc), 64'(v.tmo + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{size:8,  mss:4, tmo:0,  f0:4, f1:4, f2:0, stop_after:-1, user_beat:0, bp:0,
                exp_beats:8,  exp_err:4'b0000, exp_done:1, exp_frag:2, exp_abort:0};
    vecs[1] = '{size:10, mss:4, tmo:0,  f0:4, f1:4, f2:2, stop_after:-1, user_beat:0, bp:1,
                exp_beats:10, exp_err:4'b0000, exp_done:1, exp_frag:3, exp_abort:0};
    vecs[2] = '{size:6,  mss:4, tmo:0,  f0:4, f1:4, f2:0, stop_after:-1, user_beat:0, bp:0,
                exp_beats:6,  exp_err:4'b0100, exp_done:1, exp_frag:1, exp_abort:0};
    vecs[3] = '{size:8,  mss:4, tmo:20, f0:4, f1:4, f2:0, stop_after:4,  user_beat:0, bp:0,
                exp_beats:5,  exp_err:4'b1000, exp_done:0, exp_frag:1, exp_abort:1};
    vecs[4] = '{size:8,  mss:4, tmo:0,  f0:3, f1:5, f2:0, stop_after:-1, user_beat:0, bp:0,
                exp_beats:8,  exp_err:4'b0010, exp_done:1, exp_frag:2, exp_abort:0};
    vecs[5] = '{size:8,  mss:4, tmo:0,  f0:4, f1:4, f2:0, stop_after:-1, user_beat:2, bp:0,
                exp_beats:8,  exp_err:4'b0001, exp_done:1, exp_frag:2, exp_abort:0};
    vecs[6] = '{size:5,  mss:0, tmo:0,  f0:3, f1:2, f2:0, stop_after:-1, user_beat:0, bp:0,
                exp_beats:5,  exp_err:4'b0000, exp_done:1, exp_frag:2, exp_abort:0};
    vecs[7] = '{size:1,  mss:1, tmo:0,  f0:1, f1:0, f2:0, stop_after:-1, user_beat:0, bp:0,
                exp_beats:1,  exp_err:4'b0000, exp_done:1, exp_frag:1, exp_abort:0};

    mss = 32'd4; timeout = 32'd0; m_if.tready = 1'b1;
    drive_head();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_tready", 64'(s_if.tready), 64'd1);
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_control_dma", control_dma, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_status), 64'd0);
    chk("rst_frag_count", 64'(frag_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Zero-size command and a non-command datagram must both be ignored
    src_q.delete(); seen_busy = 1'b0;
    src_q.push_back('{data:{2'b11, 30'h3FF, 32'd0}, keep:8'hFF, last:1'b1, user:1'b0, is_cmd:1'b1, cyc:0});
    src_q.push_back('{data:{2'b10, 30'h3FF, 32'd5}, keep:8'hFF, last:1'b1, user:1'b0, is_cmd:1'b1, cyc:0});
    for (int c = 0; c < 6; c++) step(1'b0);
    chk("ign_queue_consumed", 64'(src_q.size()), 64'd0);
    chk("ign_never_busy", 64'(seen_busy), 64'd0);
    chk("ign_control_dma", control_dma, exp_ctl);

    // Reset asserted while beat 3 is on the bus
    src_q.delete(); out_q.delete(); pay_acc = 0;
    mss = 32'd4; timeout = 32'd0;
    push_cmd(9, 8);
    push_payload(9, 4, 4, 0, 4, 1);
    for (int c = 0; c < 50 && pay_acc < 2; c++) step(1'b0);
    chk("mid_two_beats_in", 64'(pay_acc), 64'd2);
    drive_head();
    m_if.tready = 1'b1;
    #1;
    chk("mid_pre_rst_err", 64'(err_status), 64'b0001);
    chk("mid_pre_rst_tvalid", 64'(m_if.tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("mid_rst_tlast", 64'(m_if.tlast), 64'd0);
    chk("mid_rst_s_tready", 64'(s_if.tready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err_status), 64'd0);
    chk("mid_rst_frag_count", 64'(frag_count), 64'd0);
    chk("mid_rst_control_dma", control_dma, 64'd0);
    src_q.delete();
    drive_head();
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(10, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
